// File: rtl/seq_pattern_transmitter.sv
// Serial pattern transmitter. It sends a latched PAT_W-bit pattern MSB first,
// repeats it count times with an optional idle gap between repetitions, and
// pulses done once the final bit has been sent.
module seq_pattern_transmitter #(
  parameter int               PAT_W       = 4,
  parameter logic [PAT_W-1:0] DEFAULT_PAT = 4'b0101,
  parameter logic             IDLE_BIT    = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             use_default,
  input  logic [PAT_W-1:0] pattern,
  input  logic [3:0]       count,
  input  logic [1:0]       gap,
  output logic             o,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int               IDX_W    = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP
  } state_t;

  state_t           r_state;
  logic [PAT_W-1:0] r_pat;
  logic [IDX_W-1:0] r_bit_idx;   // index of the bit currently on o
  logic [3:0]       r_rep_left;
  logic [1:0]       r_gap_len;
  logic [1:0]       r_gap_cnt;
  logic             r_o;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;

  logic [PAT_W-1:0] w_pat_src;
  logic [IDX_W-1:0] w_next_idx;
  logic             w_accept;

  assign w_pat_src  = use_default ? DEFAULT_PAT : pattern;
  assign w_next_idx = r_bit_idx - IDX_W'(1);
  assign w_accept   = start && !abort && (count != 4'd0);

  // NOTE: every register in this block, including the pattern latch and
  // counters, is cleared by the asynchronous reset so a reset mid-transmission
  // leaves no stale state behind; all updates use <= so each branch reads the
  // values from before the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_pat      <= '0;
      r_bit_idx  <= '0;
      r_rep_left <= '0;
      r_gap_len  <= '0;
      r_gap_cnt  <= '0;
      r_o        <= IDLE_BIT;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state    <= ST_SHIFT;
            r_pat      <= w_pat_src;
            r_rep_left <= count;
            r_gap_len  <= gap;
            r_bit_idx  <= LAST_IDX;
            r_o        <= w_pat_src[PAT_W-1];
            r_valid    <= 1'b1;
            r_busy     <= 1'b1;
          end
        end

        ST_SHIFT: begin
          if (abort) begin
            r_state <= ST_IDLE;
            r_o     <= IDLE_BIT;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end else if (r_bit_idx != '0) begin
            r_bit_idx <= w_next_idx;
            r_o       <= r_pat[w_next_idx];
          end else begin
            // LSB of a repetition is on o: close out this repetition
            if (r_rep_left != 4'd0) r_rep_left <= r_rep_left - 4'd1;
            if (r_rep_left <= 4'd1) begin
              r_state <= ST_IDLE;
              r_o     <= IDLE_BIT;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else if (r_gap_len == 2'd0) begin
              r_bit_idx <= LAST_IDX;
              r_o       <= r_pat[PAT_W-1];
            end else begin
              r_state   <= ST_GAP;
              r_gap_cnt <= r_gap_len - 2'd1;
              r_o       <= IDLE_BIT;
              r_valid   <= 1'b0;
            end
          end
        end

        ST_GAP: begin
          if (abort) begin
            r_state <= ST_IDLE;
            r_o     <= IDLE_BIT;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end else if (r_gap_cnt == 2'd0) begin
            r_state   <= ST_SHIFT;
            r_bit_idx <= LAST_IDX;
            r_o       <= r_pat[PAT_W-1];
            r_valid   <= 1'b1;
          end else begin
            r_gap_cnt <= r_gap_cnt - 2'd1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_o     <= IDLE_BIT;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o     = r_o;
  assign valid = r_valid;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_seq_pattern_transmitter.sv
// Directed testbench for seq_pattern_transmitter. Each task drives one scenario
// and compares captured output sequences against hand-computed vectors.
module tb_seq_pattern_transmitter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       use_default = 1'b0;
  logic [3:0] pattern = 4'b0000;
  logic [3:0] count = 4'd0;
  logic [1:0] gap = 2'd0;
  logic       o, valid, busy, done;

  int checks = 0;
  int failures = 0;

  // Captured sequences: the first sampled cycle ends up in the highest used bit
  logic [31:0] cap_o, cap_v, cap_b, cap_d;

  seq_pattern_transmitter dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .use_default (use_default),
    .pattern     (pattern),
    .count       (count),
    .gap         (gap),
    .o           (o),
    .valid       (valid),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cap();
    cap_o = '0;
    cap_v = '0;
    cap_b = '0;
    cap_d = '0;
  endtask

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      cap_o = {cap_o[30:0], o};
      cap_v = {cap_v[30:0], valid};
      cap_b = {cap_b[30:0], busy};
      cap_d = {cap_d[30:0], done};
      tick();
    end
  endtask

  // Returns with the outputs showing the cycle right after the accepting edge
  task automatic start_tx(input logic udef, input logic [3:0] pat,
                          input logic [3:0] cnt, input logic [1:0] gp);
    use_default = udef;
    pattern     = pat;
    count       = cnt;
    gap         = gp;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #2;
    checks++;
    if ({o, valid, busy, done} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=1000", {o, valid, busy, done});
    end
    tick();
    tick();
    @(negedge clk);
    rst = 1'b1;
    start_tx(1'b1, 4'b1111, 4'd1, 2'd0);
    checks++;
    if ({o, valid, busy, done} !== 4'b0110) begin
      failures++;
      $display("FAIL first_edge_start got=%b exp=0110", {o, valid, busy, done});
    end
    tick();
    tick();
    tick();
    tick();
  endtask

  task automatic test_single_default();
    start_tx(1'b1, 4'b1010, 4'd1, 2'd0);
    clear_cap();
    capture(5);
    checks++;
    if (cap_o !== 32'b01011) begin
      failures++;
      $display("FAIL single_o got=%b exp=01011", cap_o[4:0]);
    end
    checks++;
    if (cap_v !== 32'b11110 || cap_b !== 32'b11110) begin
      failures++;
      $display("FAIL single_valid_busy got=%b/%b exp=11110/11110", cap_v[4:0], cap_b[4:0]);
    end
    checks++;
    if (cap_d !== 32'b00001 || done !== 1'b0) begin
      failures++;
      $display("FAIL single_done got=%b then %b exp=00001 then 0", cap_d[4:0], done);
    end
  endtask

  task automatic test_repeat_no_gap();
    start_tx(1'b1, 4'b0000, 4'd3, 2'd0);
    clear_cap();
    capture(13);
    checks++;
    if (cap_o !== 32'b0101010101011) begin
      failures++;
      $display("FAIL rep3_o got=%b exp=0101010101011", cap_o[12:0]);
    end
    checks++;
    if (cap_b !== 32'b1111111111110 || cap_v !== 32'b1111111111110) begin
      failures++;
      $display("FAIL rep3_busy_valid got=%b/%b exp=1111111111110", cap_b[12:0], cap_v[12:0]);
    end
    checks++;
    if (cap_d !== 32'b0000000000001) begin
      failures++;
      $display("FAIL rep3_done got=%b exp=0000000000001", cap_d[12:0]);
    end
  endtask

  task automatic test_gap();
    start_tx(1'b0, 4'b1100, 4'd2, 2'd2);
    clear_cap();
    capture(11);
    checks++;
    if (cap_o !== 32'b11001111001) begin
      failures++;
      $display("FAIL gap_o got=%b exp=11001111001", cap_o[10:0]);
    end
    checks++;
    if (cap_v !== 32'b11110011110) begin
      failures++;
      $display("FAIL gap_valid got=%b exp=11110011110", cap_v[10:0]);
    end
    checks++;
    if (cap_b !== 32'b11111111110 || cap_d !== 32'b00000000001) begin
      failures++;
      $display("FAIL gap_busy_done got=%b/%b exp=11111111110/00000000001", cap_b[10:0], cap_d[10:0]);
    end
  endtask

  task automatic test_abort();
    start_tx(1'b1, 4'b0000, 4'd3, 2'd0);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({o, valid, busy, done} !== 4'b1000) begin
      failures++;
      $display("FAIL abort_shift got=%b exp=1000", {o, valid, busy, done});
    end
    clear_cap();
    capture(6);
    checks++;
    if (cap_d !== 32'd0 || cap_b !== 32'd0) begin
      failures++;
      $display("FAIL abort_no_done done=%b busy=%b exp=0", cap_d[5:0], cap_b[5:0]);
    end
    // Abort while in the gap
    start_tx(1'b0, 4'b1100, 4'd2, 2'd3);
    capture(5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({o, valid, busy, done} !== 4'b1000) begin
      failures++;
      $display("FAIL abort_gap got=%b exp=1000", {o, valid, busy, done});
    end
  endtask

  task automatic test_async_reset();
    start_tx(1'b0, 4'b1100, 4'd2, 2'd3);
    capture(5);
    checks++;
    if ({valid, busy} !== 2'b01) begin
      failures++;
      $display("FAIL pre_reset_gap got=%b exp=01", {valid, busy});
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({o, valid, busy, done} !== 4'b1000) begin
      failures++;
      $display("FAIL async_reset got=%b exp=1000", {o, valid, busy, done});
    end
    tick();
    @(negedge clk);
    rst = 1'b1;
    start_tx(1'b1, 4'b0000, 4'd1, 2'd0);
    clear_cap();
    capture(5);
    checks++;
    if (cap_o !== 32'b01011 || cap_d !== 32'b00001) begin
      failures++;
      $display("FAIL post_reset_tx o=%b done=%b exp=01011/00001", cap_o[4:0], cap_d[4:0]);
    end
  endtask

  task automatic test_ignored_starts();
    start_tx(1'b1, 4'b0000, 4'd0, 2'd0);
    clear_cap();
    capture(3);
    checks++;
    if (cap_b !== 32'd0 || cap_v !== 32'd0 || cap_d !== 32'd0) begin
      failures++;
      $display("FAIL count_zero busy=%b valid=%b done=%b exp=0", cap_b[2:0], cap_v[2:0], cap_d[2:0]);
    end
    abort = 1'b1;
    start_tx(1'b1, 4'b0000, 4'd1, 2'd0);
    abort = 1'b0;
    checks++;
    if ({valid, busy} !== 2'b00) begin
      failures++;
      $display("FAIL abort_wins got=%b exp=00", {valid, busy});
    end
    // Start and input changes while busy must not disturb the transmission
    start_tx(1'b0, 4'b1100, 4'd1, 2'd0);
    use_default = 1'b1;
    pattern     = 4'b0011;
    count       = 4'd15;
    gap         = 2'd3;
    start       = 1'b1;
    clear_cap();
    capture(2);
    start = 1'b0;
    capture(3);
    checks++;
    if (cap_o !== 32'b11001 || cap_d !== 32'b00001) begin
      failures++;
      $display("FAIL busy_start_o got=%b done=%b exp=11001/00001", cap_o[4:0], cap_d[4:0]);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_start_idle got=%b exp=0", busy);
    end
  endtask

  task automatic test_back_to_back();
    start_tx(1'b1, 4'b0000, 4'd1, 2'd0);
    capture(4);
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL b2b_done got=%b exp=1", done);
    end
    start_tx(1'b0, 4'b1100, 4'd1, 2'd0);
    checks++;
    if ({o, valid, busy, done} !== 4'b1110) begin
      failures++;
      $display("FAIL b2b_accept got=%b exp=1110", {o, valid, busy, done});
    end
    clear_cap();
    capture(5);
    checks++;
    if (cap_o !== 32'b11001 || cap_d !== 32'b00001) begin
      failures++;
      $display("FAIL b2b_second o=%b done=%b exp=11001/00001", cap_o[4:0], cap_d[4:0]);
    end
  endtask

  task automatic test_max_count();
    int n_busy;
    int n_valid;
    n_busy  = 0;
    n_valid = 0;
    start_tx(1'b0, 4'b1011, 4'd15, 2'd3);
    for (int i = 0; i < 200 && !done; i++) begin
      if (busy) n_busy++;
      if (valid) n_valid++;
      tick();
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL max_timeout done=%b exp=1", done);
    end
    checks++;
    if (n_busy != 102 || n_valid != 60) begin
      failures++;
      $display("FAIL max_lengths busy=%0d valid=%0d exp=102/60", n_busy, n_valid);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_default();
    test_repeat_no_gap();
    test_gap();
    test_abort();
    test_async_reset();
    test_ignored_starts();
    test_back_to_back();
    test_max_count();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_pattern_transmitter.md
SEQ_PATTERN_TRANSMITTER -- requirements
Module: seq_pattern_transmitter

Interface
REQ-001 The block SHALL have parameter PAT_W, default 4, meaning pattern length in bits.
REQ-002 The block SHALL have parameter DEFAULT_PAT, default 4'b0101, meaning the pattern sent when use_default=1.
REQ-003 The block SHALL have parameter IDLE_BIT, default 1'b1, meaning the level of o while not sending a pattern bit.
REQ-004 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 Port rst  input  1  reset, asynchronous, active-low.
REQ-006 Port start  input  1  request to begin a transmission; sampled only in IDLE.
REQ-007 Port abort  input  1  synchronous cancel of the current transmission.
REQ-008 Port use_default  input  1  1 selects DEFAULT_PAT, 0 selects pattern; sampled with start.
REQ-009 Port pattern  input  PAT_W  pattern to send, MSB first; sampled with start.
REQ-010 Port count  input  4  number of pattern repetitions, 1..15; sampled with start.
REQ-011 Port gap  input  2  idle cycles between repetitions, 0..3; sampled with start.
REQ-012 Port o  output  1  serial bit stream, registered.
REQ-013 Port valid  output  1  high when o carries a pattern bit, registered.
REQ-014 Port busy  output  1  high from the first pattern bit through the last bit, registered.
REQ-015 Port done  output  1  one-cycle pulse after normal completion, registered.

Function
REQ-016 The FSM SHALL have states IDLE, SHIFT and GAP; SHIFT emits pattern bits, GAP emits IDLE_BIT.
REQ-017 In IDLE, start=1 with count!=0 and abort=0 SHALL latch the pattern source, count and gap, and enter SHIFT.
REQ-018 Latency: o SHALL show the latched MSB with valid=1 and busy=1 in the cycle immediately after the accepting edge.
REQ-019 Each pattern bit SHALL be held on o for exactly one clock, MSB to LSB, so one repetition takes PAT_W cycles.
REQ-020 After the LSB of a repetition that is not the last: gap=0 SHALL continue in SHIFT with the next MSB (no bubble); gap>0 SHALL enter GAP for exactly gap cycles.
REQ-021 In GAP, o SHALL be IDLE_BIT, valid SHALL be 0 and busy SHALL be 1.
REQ-022 After the LSB of the last repetition, the FSM SHALL return to IDLE; in that next cycle done=1, busy=0, valid=0 and o=IDLE_BIT.
REQ-023 A full transmission SHALL keep busy high for exactly count*PAT_W + (count-1)*gap cycles.
REQ-024 start with count=0 SHALL be ignored: no state change and no done.
REQ-025 start SHALL be ignored while busy=1.
REQ-026 start in the cycle done=1 SHALL be accepted, so back-to-back transmissions are allowed.
REQ-027 Changes on pattern, count, gap or use_default while busy=1 SHALL NOT affect the transmission in progress.
REQ-028 abort=1 in SHIFT or GAP SHALL return the FSM to IDLE at the next edge, with o=IDLE_BIT, valid=0, busy=0 and done=0.
REQ-029 abort and start both high in IDLE SHALL leave the FSM in IDLE (abort wins).
REQ-030 The repetition counter SHALL decrement once per completed repetition and SHALL NOT wrap below zero.

Reset
REQ-031 While rst=0, asynchronously and independent of clk: state=IDLE, o=IDLE_BIT, valid=0, busy=0, done=0, all internal counters and latches cleared.
REQ-032 Reset asserted mid-transmission SHALL discard it with no done pulse.
REQ-033 The first rising edge after rst deasserts SHALL accept a start.

Verification
REQ-034 use_default=1, count=1, gap=0, pulse start -> o=0,1,0,1 with valid=1 and busy=1 for 4 cycles, then done=1 for 1 cycle with o=1.
REQ-035 use_default=1, count=3, gap=0 -> o=010101010101 continuous, busy high for 12 cycles, a single done pulse.
REQ-036 pattern=4'b1100, use_default=0, count=2, gap=2 -> o=1,1,0,0,1,1,1,1,0,0; valid=1111001111; busy high for 10 cycles.
REQ-037 abort after 2 bits of 0101 -> next cycle o=1, valid=0, busy=0; done never asserts.
REQ-038 rst driven low mid-GAP between clock edges -> outputs reach reset values without waiting for clk; a new start after release sends a full pattern.
REQ-039 count=0 start -> nothing sent; start while busy -> ignored; start during done -> second transmission begins the next cycle.
